z_event_counter: RTL and testbench
==================================

Name: z_event_counter

Overview:
- Downstream consumer of the lab 7 sequence-detector output z.
- Registers z, detects each new detection event (rising edge of z), and counts events in two-digit BCD for the HEX displays.
- Tracks the current and longest run of consecutive z=1 cycles, which shows how long the detector stayed in a match state.
- Runs in the same clock domain as the FSM, so z needs no synchronizer.

Parameters:
- RUN_W, 8, width of the run-length counter and the max-run register.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- z  in  1  detector output, synchronous to clk
- clr  in  1  synchronous clear of counts and flags; does not clear z_d
- evt  out  1  one-cycle registered pulse per counted event
- event_bcd  out  8  [7:4] tens digit, [3:0] ones digit, each 0-9
- ovf  out  1  sticky flag, set when an increment is attempted at 99
- run_len  out  RUN_W  current consecutive-high count of z
- max_run  out  RUN_W  longest run_len since reset or clr

Behaviour:
- Reset: at the clk edge with rst=1, z_d, evt, event_bcd, ovf, run_len and max_run all go to 0.
- Priority: rst > clr > normal operation.
- Edge detect: z_d <= z every cycle; rise = z & ~z_d.
  - The z_d reset value of 0 means z held high through reset counts as one event at the first edge after reset.
- Event count latency: the edge that samples rise=1 also updates the outputs.
  - evt=1 and event_bcd=old+1, both visible after that edge.
  - evt is high for exactly one cycle per rise.
- BCD increment:
  - Ones digit 9->0 with a carry into tens.
  - Tens increments only on that carry.
  - Digits never hold values 10-15.
- Wrap at 99 (macro absent): 99 -> 00 and ovf <= 1. ovf stays 1 until rst or clr.
- Run length:
  - z=1: run_len <= run_len+1, saturating at 2^RUN_W-1.
  - z=0: run_len <= 0.
- Max run:
  - max_run <= max(max_run, next run_len) every cycle.
  - A run is therefore reflected in max_run in the same cycle run_len updates.
- clr behaviour:
  - clr=1 zeroes evt, event_bcd, ovf, run_len and max_run.
  - z_d still updates.
  - A rise in the same cycle as clr is dropped; the count stays 0.
- Back-to-back: z pattern 1,0,1 on consecutive cycles gives two events, two evt pulses two cycles apart.
- Held high: z held high for N cycles gives exactly one event and run_len=N (saturated if N exceeds the range).
- Reset mid-run: after rst, z still high does not count a new event only if z_d was 1 before the reset edge.
  - Because rst zeroes z_d, this case counts one event at the next edge (same rule as the reset bullet above).

Optional Feature:
- Macro: Z_EVENT_COUNT_SAT_EN.
- Defined: event_bcd saturates at 99, and an increment attempted at 99 sets ovf while the count stays 99.
- Undefined: wraps 99 -> 00 with the sticky ovf described above.
- Run-length behaviour is identical either way.

Decomposition:
- Shared package/header holds:
  - BCD_DIGIT_W=4
  - BCD_MAX=4'd9
  - EVENT_DIGITS=2
- One sub-module, bcd_digit:
  - Inputs: clk, rst, clr, inc.
  - Outputs: q[3:0] and carry, where carry is asserted when inc and q==9.
  - Two instances are chained, ones driving tens.
- Run-length logic stays inline.

Test Plan:
- Reset: rst=1 for 5 cycles with z=1 → all outputs 0 during reset; first edge after rst drops gives evt=1, event_bcd=8'h01.
- Single pulse: z=1 for 1 cycle (40 ns period) then 0 → evt high for one cycle, event_bcd=8'h01, run_len=1 then 0, max_run=1.
- Long run: z=1 for 5 cycles → one event, run_len counts 1..5, max_run=5; a later 2-cycle run leaves max_run=5.
- BCD carry and wrap: 100 isolated pulses.
  - After 9 pulses event_bcd=8'h09, after 10 pulses 8'h10.
  - After 99 pulses 8'h99, after 100 pulses 8'h00 with ovf=1.
  - With Z_EVENT_COUNT_SAT_EN defined, after 100 pulses: 8'h99, ovf=1.
- clr collision: assert clr in the same cycle as a z rise with event_bcd=8'h42 → next event_bcd=8'h00, evt=0, ovf=0, max_run=0.
- Saturation: RUN_W=3 with z held high for 10 cycles → run_len sticks at 7, max_run=7, exactly one event.

Source files
------------

// File: rtl/z_event_counter_pkg.sv
// Shared constants for the z event counter: BCD digit geometry and limits.
package z_event_counter_pkg;

    localparam int                     BCD_DIGIT_W  = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX      = 4'd9;
    localparam int                     EVENT_DIGITS = 2;
    localparam int                     EVENT_W      = EVENT_DIGITS * BCD_DIGIT_W;

    // All-nines pattern across every event digit, i.e. the top of the count range.
    function automatic logic [EVENT_W-1:0] bcd_all_max();
        logic [EVENT_W-1:0] v;
        v = '0;
        for (int i = 0; i < EVENT_DIGITS; i++) begin
            v[i*BCD_DIGIT_W +: BCD_DIGIT_W] = BCD_MAX;
        end
        return v;
    endfunction

endpackage

// File: rtl/z_event_counter_bcd_digit.sv
// One decimal digit (0-9) with increment, clear, and carry-out on 9 -> 0.
module z_event_counter_bcd_digit
    import z_event_counter_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    output logic [BCD_DIGIT_W-1:0] q,
    output logic                   carry
);

    assign carry = inc && (q == BCD_MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= carry ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/z_event_counter.sv
// Counts rising edges of detector output z in two-digit BCD and tracks z=1 run lengths.
// Define Z_EVENT_COUNT_SAT_EN to saturate the count at 99 instead of wrapping to 00.
module z_event_counter
    import z_event_counter_pkg::*;
#(
    parameter int RUN_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               z,
    input  logic               clr,
    output logic               evt,
    output logic [EVENT_W-1:0] event_bcd,
    output logic               ovf,
    output logic [RUN_W-1:0]   run_len,
    output logic [RUN_W-1:0]   max_run
);

    logic                   z_d;
    logic                   rise;
    logic                   at_max;
    logic                   ones_inc;
    logic                   ones_carry;
    logic                   tens_carry;
    logic                   ovf_set;
    logic [BCD_DIGIT_W-1:0] ones_q;
    logic [BCD_DIGIT_W-1:0] tens_q;
    logic [RUN_W-1:0]       run_next;

    assign rise      = z && !z_d;
    assign event_bcd = {tens_q, ones_q};
    assign at_max    = (event_bcd == bcd_all_max());

`ifdef Z_EVENT_COUNT_SAT_EN
    assign ones_inc = rise && !at_max;
`else
    assign ones_inc = rise;
`endif
    // Wrap mode sees the attempt as tens_carry; saturating mode blocks the carry, so test at_max too.
    assign ovf_set = tens_carry || (rise && at_max);

    z_event_counter_bcd_digit u_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (ones_inc),
        .q     (ones_q),
        .carry (ones_carry)
    );

    z_event_counter_bcd_digit u_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (ones_carry),
        .q     (tens_q),
        .carry (tens_carry)
    );

    always_comb begin
        run_next = '0;
        if (z) begin
            run_next = (run_len == '1) ? run_len : run_len + 1'b1;
        end
    end

    // z_d keeps tracking z through clr so a rise swallowed by clr is never counted later.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_d <= 1'b0;
        end else begin
            z_d <= z;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            evt     <= 1'b0;
            ovf     <= 1'b0;
            run_len <= '0;
            max_run <= '0;
        end else begin
            evt     <= rise;
            ovf     <= ovf || ovf_set;
            run_len <= run_next;
            max_run <= (run_next > max_run) ? run_next : max_run;
        end
    end

endmodule

// File: tb/tb_z_event_counter.sv
// Randomized and directed bench for z_event_counter, checked against an arithmetic event/run model.
module tb_z_event_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       z   = 1'b0;
    logic       clr = 1'b0;

    logic       evt,     evt_s;
    logic [7:0] bcd,     bcd_s;
    logic       ovf,     ovf_s;
    logic [7:0] run_len, max_run;
    logic [2:0] run_len_s, max_run_s;

    int n_cmp  = 0;
    int n_fail = 0;

    always #20 clk = ~clk;

    z_event_counter #(.RUN_W(8)) u_dut (
        .clk(clk), .rst(rst), .z(z), .clr(clr),
        .evt(evt), .event_bcd(bcd), .ovf(ovf), .run_len(run_len), .max_run(max_run)
    );

    z_event_counter #(.RUN_W(3)) u_dut_small (
        .clk(clk), .rst(rst), .z(z), .clr(clr),
        .evt(evt_s), .event_bcd(bcd_s), .ovf(ovf_s), .run_len(run_len_s), .max_run(max_run_s)
    );

    // Model: count of rises since rst/clr, unbounded current run and longest run.
    bit m_valid  = 0;
    bit m_prev_z = 0;
    bit m_evt    = 0;
    bit m_rise;
    int m_events = 0;
    int m_run    = 0;
    int m_max    = 0;

    function automatic logic [7:0] exp_bcd(input int n);
        int v;
`ifdef Z_EVENT_COUNT_SAT_EN
        v = (n > 99) ? 99 : n;
`else
        v = n % 100;
`endif
        return 8'((v / 10) * 16 + (v % 10));
    endfunction

    function automatic int sat_w(input int v, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (v > lim) ? lim : v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1;
            m_prev_z = 0;
            m_evt    = 0;
            m_events = 0;
            m_run    = 0;
            m_max    = 0;
        end else begin
            m_rise   = z && !m_prev_z;
            m_prev_z = z;
            if (clr) begin
                m_evt    = 0;
                m_events = 0;
                m_run    = 0;
                m_max    = 0;
            end else begin
                m_evt = m_rise;
                if (m_rise) m_events++;
                m_run = z ? m_run + 1 : 0;
                if (m_run > m_max) m_max = m_run;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("evt",         32'(evt),       32'(m_evt));
            check("event_bcd",   32'(bcd),       32'(exp_bcd(m_events)));
            check("ovf",         32'(ovf),       32'(m_events >= 100));
            check("run_len",     32'(run_len),   32'(sat_w(m_run, 8)));
            check("max_run",     32'(max_run),   32'(sat_w(m_max, 8)));
            check("evt_w3",      32'(evt_s),     32'(m_evt));
            check("event_bcd_w3",32'(bcd_s),     32'(exp_bcd(m_events)));
            check("ovf_w3",      32'(ovf_s),     32'(m_events >= 100));
            check("run_len_w3",  32'(run_len_s), 32'(sat_w(m_run, 3)));
            check("max_run_w3",  32'(max_run_s), 32'(sat_w(m_max, 3)));
        end
    end

    task automatic step(input logic zi, input logic ci, input logic ri);
        z   = zi;
        clr = ci;
        rst = ri;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with z high: outputs stay zero, then one event on release.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        check("rst_bcd", 32'(bcd), 32'h00);
        check("rst_evt", 32'(evt), 32'h0);
        check("rst_run", 32'(run_len), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        check("post_rst_evt", 32'(evt), 32'h1);
        check("post_rst_bcd", 32'(bcd), 32'h01);
        step(1'b1, 1'b0, 1'b0);
        check("held_evt", 32'(evt), 32'h0);
        step(1'b0, 1'b0, 1'b0);

        // Single pulse.
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("pulse_evt", 32'(evt), 32'h1);
        check("pulse_bcd", 32'(bcd), 32'h01);
        check("pulse_run", 32'(run_len), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("pulse_evt_low", 32'(evt), 32'h0);
        check("pulse_run_low", 32'(run_len), 32'h0);
        check("pulse_max", 32'(max_run), 32'h1);

        // Long run, then a shorter run that must not lower max_run; then 1,0,1.
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
            check("long_run", 32'(run_len), 32'(i));
        end
        check("long_max", 32'(max_run), 32'h5);
        check("long_bcd", 32'(bcd), 32'h02);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("short_max", 32'(max_run), 32'h5);
        check("short_bcd", 32'(bcd), 32'h03);
        step(1'b1, 1'b0, 1'b0);
        check("b2b_evt1", 32'(evt), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("b2b_evt2", 32'(evt), 32'h1);
        check("b2b_bcd", 32'(bcd), 32'h05);
        step(1'b0, 1'b0, 1'b0);

        // 100 isolated pulses: carry and wrap/saturate.
        step(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            step(1'b1, 1'b0, 1'b0);
            if (k == 9)  check("cnt9",  32'(bcd), 32'h09);
            if (k == 10) check("cnt10", 32'(bcd), 32'h10);
            if (k == 99) begin
                check("cnt99", 32'(bcd), 32'h99);
                check("ovf99", 32'(ovf), 32'h0);
            end
            if (k == 100) begin
`ifdef Z_EVENT_COUNT_SAT_EN
                check("cnt100", 32'(bcd), 32'h99);
`else
                check("cnt100", 32'(bcd), 32'h00);
`endif
                check("ovf100", 32'(ovf), 32'h1);
            end
            step(1'b0, 1'b0, 1'b0);
        end
        check("ovf_sticky", 32'(ovf), 32'h1);

        // clr colliding with a rise at count 42.
        step(1'b0, 1'b1, 1'b0);
        check("clr_ovf", 32'(ovf), 32'h0);
        for (int k = 0; k < 42; k++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check("cnt42", 32'(bcd), 32'h42);
        step(1'b1, 1'b1, 1'b0);
        check("coll_bcd", 32'(bcd), 32'h00);
        check("coll_evt", 32'(evt), 32'h0);
        check("coll_ovf", 32'(ovf), 32'h0);
        check("coll_max", 32'(max_run), 32'h0);
        step(1'b1, 1'b0, 1'b0);
        check("coll_after_bcd", 32'(bcd), 32'h00);
        check("coll_after_run", 32'(run_len), 32'h1);
        step(1'b0, 1'b0, 1'b0);

        // Run-length saturation on both widths.
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
        check("sat3_run", 32'(run_len_s), 32'h7);
        check("sat3_max", 32'(max_run_s), 32'h7);
        check("sat3_bcd", 32'(bcd_s), 32'h01);
        check("w8_run10", 32'(run_len), 32'd10);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b0);
        check("sat8_run", 32'(run_len), 32'd255);
        check("sat8_max", 32'(max_run), 32'd255);
        step(1'b0, 1'b0, 1'b0);

        // Random traffic: frequent clr first, then rare clr so the count reaches the overflow range.
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 299) == 0));
        end
        for (int i = 0; i < 2000; i++) begin
            step(1'($urandom_range(0, 99) < 50),
                 1'($urandom_range(0, 1499) == 0),
                 1'($urandom_range(0, 1999) == 0));
        end
        step(1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
